// File: rtl/tlb_op_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_op_ctrl
// Puts the CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) onto the MMU's TLB
// maintenance ports and returns the results to CP0. The block also owns the
// MIPS Random register.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op_valid, op_type   op request from execute (00 P, 01 R, 10 WI, 11 WR)
//   op_ready, busy      idle / op in flight (pipeline stall)
//   cp0_index           CP0 Index, used by TLBR/TLBWI
//   cp0_wired(_we)      CP0 Wired value and its write strobe
//   cp0_tlb_config      packed EntryHi/PageMask/EntryLo0/1
//   random_o            CP0 Random register
//   tlb_config, tlb_we_index, tlb_we, tlb_p, tlb_read_index   to mmu
//   tlb_p_res_i, tlb_read_config_i                            from mmu
//   res_valid, res_type, res_index, res_config                to CP0
// -----------------------------------------------------------------------------
module tlb_op_ctrl #(
    parameter int ENABLE_TLB = 1,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       op_type,
    output logic             op_ready,
    output logic             busy,
    input  logic [IDX_W-1:0] cp0_index,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             cp0_wired_we,
    input  logic [85:0]      cp0_tlb_config,
    output logic [IDX_W-1:0] random_o,
    output logic [85:0]      tlb_config,
    output logic [IDX_W-1:0] tlb_we_index,
    output logic             tlb_we,
    output logic             tlb_p,
    output logic [IDX_W-1:0] tlb_read_index,
    input  logic [31:0]      tlb_p_res_i,
    input  logic [85:0]      tlb_read_config_i,
    output logic             res_valid,
    output logic [1:0]       res_type,
    output logic [31:0]      res_index,
    output logic [85:0]      res_config
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    localparam logic [IDX_W-1:0] RAND_TOP  = {IDX_W{1'b1}};
    localparam logic [31:0]      PROBE_MISS = 32'h8000_0000;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [IDX_W-1:0] random_r;
    logic [IDX_W-1:0] random_nxt_s;
    logic [IDX_W-1:0] op_index_s;
    logic             accept_s;
    logic [1:0]       op_type_r;
    logic [85:0]      tlb_config_r;
    logic [IDX_W-1:0] idx_r;
    logic             tlb_we_r;
    logic             tlb_p_r;
    logic             res_valid_r;
    logic [31:0]      res_index_r;
    logic [85:0]      res_config_r;

    assign accept_s       = op_valid && (state_r == ST_IDLE);
    assign op_ready       = (state_r == ST_IDLE);
    assign busy           = (state_r != ST_IDLE);
    assign random_o       = random_r;
    assign tlb_config     = tlb_config_r;
    assign tlb_we_index   = idx_r;
    assign tlb_read_index = idx_r;
    assign tlb_we         = tlb_we_r;
    assign tlb_p          = tlb_p_r;
    assign res_valid      = res_valid_r;
    assign res_type       = op_type_r;
    assign res_index      = res_index_r;
    assign res_config     = res_config_r;

    // Next FSM state; without a TLB an accepted op goes straight to DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (op_valid) begin
                    state_nxt_s = (ENABLE_TLB != 0) ? ST_ISSUE : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE:   state_nxt_s = ST_CAPTURE;
            ST_CAPTURE: state_nxt_s = ST_DONE;
            ST_DONE:    state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Random decrements toward Wired. It reloads to the top entry when Wired
    // is written, or when it is at or below Wired, which also covers the wrap.
    always_comb begin
        random_nxt_s = random_r;
        if (cp0_wired_we) begin
            random_nxt_s = RAND_TOP;
        end else if (random_r <= cp0_wired) begin
            random_nxt_s = RAND_TOP;
        end else begin
            random_nxt_s = random_r - {{(IDX_W-1){1'b0}}, 1'b1};
        end
    end

    // TLBWR targets the Random value seen at the accept edge. Every other op uses Index.
    always_comb begin
        op_index_s = cp0_index;
        if (op_type == OP_TLBWR) begin
            op_index_s = random_r;
        end else begin
            op_index_s = cp0_index;
        end
    end

    // FSM state and Random register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            random_r <= RAND_TOP;
        end else begin
            state_r  <= state_nxt_s;
            random_r <= random_nxt_s;
        end
    end

    // Operand latch at accept. The values are held until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_type_r    <= 2'b00;
            tlb_config_r <= 86'd0;
            idx_r        <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            op_type_r    <= op_type;
            tlb_config_r <= cp0_tlb_config;
            idx_r        <= op_index_s;
        end else begin
            op_type_r    <= op_type_r;
            tlb_config_r <= tlb_config_r;
            idx_r        <= idx_r;
        end
    end

    // One-cycle MMU strobes, raised in the cycle right after accept (ISSUE).
    always_ff @(posedge clk) begin
        if (rst) begin
            tlb_we_r <= 1'b0;
            tlb_p_r  <= 1'b0;
        end else if (accept_s && (ENABLE_TLB != 0)) begin
            tlb_we_r <= op_type[1];
            tlb_p_r  <= (op_type == OP_TLBP);
        end else begin
            tlb_we_r <= 1'b0;
            tlb_p_r  <= 1'b0;
        end
    end

    // Result registers and the completion pulse. With a TLB the MMU answer is
    // captured leaving CAPTURE. Without a TLB fixed results are loaded at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r  <= 1'b0;
            res_index_r  <= 32'd0;
            res_config_r <= 86'd0;
        end else if ((ENABLE_TLB != 0) && (state_r == ST_CAPTURE)) begin
            res_valid_r <= 1'b1;
            if (op_type_r == OP_TLBP) begin
                res_index_r <= tlb_p_res_i;
            end else if (op_type_r == OP_TLBR) begin
                res_config_r <= tlb_read_config_i;
            end else begin
                res_index_r <= res_index_r;
            end
        end else if ((ENABLE_TLB == 0) && accept_s) begin
            res_valid_r <= 1'b1;
            if (op_type == OP_TLBP) begin
                res_index_r <= PROBE_MISS;
            end else if (op_type == OP_TLBR) begin
                res_config_r <= 86'd0;
            end else begin
                res_index_r <= res_index_r;
            end
        end else begin
            res_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
module tb_tlb_op_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [3:0]  cp0_index, cp0_wired;
    logic        cp0_wired_we;
    logic [85:0] cp0_tlb_config;
    logic [31:0] tlb_p_res_i;
    logic [85:0] tlb_read_config_i;

    logic        op_ready, busy, tlb_we, tlb_p, res_valid;
    logic [3:0]  random_o, tlb_we_index, tlb_read_index;
    logic [85:0] tlb_config, res_config;
    logic [1:0]  res_type;
    logic [31:0] res_index;

    logic        op_ready0, busy0, tlb_we0, tlb_p0, res_valid0;
    logic [3:0]  random_o0, tlb_we_index0, tlb_read_index0;
    logic [85:0] tlb_config0, res_config0;
    logic [1:0]  res_type0;
    logic [31:0] res_index0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    tlb_op_ctrl #(.ENABLE_TLB(1), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
        .op_ready(op_ready), .busy(busy), .cp0_index(cp0_index),
        .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we),
        .cp0_tlb_config(cp0_tlb_config), .random_o(random_o),
        .tlb_config(tlb_config), .tlb_we_index(tlb_we_index), .tlb_we(tlb_we),
        .tlb_p(tlb_p), .tlb_read_index(tlb_read_index), .tlb_p_res_i(tlb_p_res_i),
        .tlb_read_config_i(tlb_read_config_i), .res_valid(res_valid),
        .res_type(res_type), .res_index(res_index), .res_config(res_config)
    );

    tlb_op_ctrl #(.ENABLE_TLB(0), .IDX_W(4)) dut0 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
        .op_ready(op_ready0), .busy(busy0), .cp0_index(cp0_index),
        .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we),
        .cp0_tlb_config(cp0_tlb_config), .random_o(random_o0),
        .tlb_config(tlb_config0), .tlb_we_index(tlb_we_index0), .tlb_we(tlb_we0),
        .tlb_p(tlb_p0), .tlb_read_index(tlb_read_index0), .tlb_p_res_i(tlb_p_res_i),
        .tlb_read_config_i(tlb_read_config_i), .res_valid(res_valid0),
        .res_type(res_type0), .res_index(res_index0), .res_config(res_config0)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [85:0] rnd86();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[85:0];
    endfunction

    // Reference model. An op is tracked as "cycles left until idle". With a
    // TLB that is 3 cycles after accept: strobe cycle, capture cycle and result
    // cycle. Without a TLB it is 1 cycle, the result cycle.
    int          m_rem, m0_rem;
    logic [3:0]  m_rand, m_idx, m0_idx;
    logic [1:0]  m_type, m0_type;
    logic [85:0] m_cfg, m_resc, m0_cfg, m0_resc;
    logic [31:0] m_resi, m0_resi;

    always @(posedge clk) begin
        if (rst) begin
            m_rand <= 4'd15;
            m_rem <= 0;   m_type <= 2'd0;  m_cfg <= 86'd0;  m_idx <= 4'd0;  m_resi <= 32'd0;  m_resc <= 86'd0;
            m0_rem <= 0;  m0_type <= 2'd0; m0_cfg <= 86'd0; m0_idx <= 4'd0; m0_resi <= 32'd0; m0_resc <= 86'd0;
        end else begin
            m_rand <= (cp0_wired_we || (m_rand <= cp0_wired)) ? 4'd15 : m_rand - 4'd1;
            if (m_rem == 0) begin
                if (op_valid) begin
                    m_rem  <= 3;
                    m_type <= op_type;
                    m_cfg  <= cp0_tlb_config;
                    m_idx  <= (op_type == 2'd3) ? m_rand : cp0_index;
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 2 && m_type == 2'd0) m_resi <= tlb_p_res_i;
                if (m_rem == 2 && m_type == 2'd1) m_resc <= tlb_read_config_i;
            end
            if (m0_rem == 0) begin
                if (op_valid) begin
                    m0_rem  <= 1;
                    m0_type <= op_type;
                    m0_cfg  <= cp0_tlb_config;
                    m0_idx  <= (op_type == 2'd3) ? m_rand : cp0_index;
                    if (op_type == 2'd0) m0_resi <= 32'h8000_0000;
                    if (op_type == 2'd1) m0_resc <= 86'd0;
                end
            end else begin
                m0_rem <= m0_rem - 1;
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready",     128'(op_ready),       128'(m_rem == 0));
            chk("busy",      128'(busy),           128'(m_rem != 0));
            chk("we",        128'(tlb_we),         128'((m_rem == 3) && m_type[1]));
            chk("p",         128'(tlb_p),          128'((m_rem == 3) && (m_type == 2'd0)));
            chk("rvalid",    128'(res_valid),      128'(m_rem == 1));
            chk("rtype",     128'(res_type),       128'(m_type));
            chk("random",    128'(random_o),       128'(m_rand));
            chk("cfg",       128'(tlb_config),     128'(m_cfg));
            chk("we_idx",    128'(tlb_we_index),   128'(m_idx));
            chk("rd_idx",    128'(tlb_read_index), 128'(m_idx));
            chk("res_index", 128'(res_index),      128'(m_resi));
            chk("res_cfg",   128'(res_config),     128'(m_resc));
            chk("ready0",    128'(op_ready0),       128'(m0_rem == 0));
            chk("busy0",     128'(busy0),           128'(m0_rem != 0));
            chk("we0",       128'(tlb_we0),         128'(0));
            chk("p0",        128'(tlb_p0),          128'(0));
            chk("rvalid0",   128'(res_valid0),      128'(m0_rem == 1));
            chk("rtype0",    128'(res_type0),       128'(m0_type));
            chk("random0",   128'(random_o0),       128'(m_rand));
            chk("cfg0",      128'(tlb_config0),     128'(m0_cfg));
            chk("we_idx0",   128'(tlb_we_index0),   128'(m0_idx));
            chk("res_index0",128'(res_index0),      128'(m0_resi));
            chk("res_cfg0",  128'(res_config0),     128'(m0_resc));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] t, input logic [3:0] idx, input logic [85:0] cfg);
        op_valid = 1'b1; op_type = t; cp0_index = idx; cp0_tlb_config = cfg;
        tick();
        op_valid = 1'b0;
    endtask

    logic [85:0] xcfg, pcfg;
    bit found;

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_type = 2'd0; cp0_index = 4'd0; cp0_wired = 4'd0;
        cp0_wired_we = 1'b0; cp0_tlb_config = 86'd0; tlb_p_res_i = 32'd0; tlb_read_config_i = 86'd0;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_ready",  128'(op_ready),  128'(1));
        chk("rst_busy",   128'(busy),      128'(0));
        chk("rst_random", 128'(random_o),  128'(15));
        chk("rst_rvalid", 128'(res_valid), 128'(0));
        chk("rst_cfg",    128'(tlb_config),128'(0));
        rst = 1'b0;

        // Random walk with Wired=0: 15 down to 0, then wrap to 15
        for (int i = 0; i <= 16; i++) begin
            chk("rand_seq", 128'(random_o), 128'((i == 16) ? 15 : 15 - i));
            tick();
        end
        // Wired=12: write Wired, then 15,14,13,12,15
        cp0_wired = 4'd12; cp0_wired_we = 1'b1;
        tick();
        cp0_wired_we = 1'b0;
        chk("w12_a", 128'(random_o), 128'(15)); tick();
        chk("w12_b", 128'(random_o), 128'(14)); tick();
        chk("w12_c", 128'(random_o), 128'(13)); tick();
        chk("w12_d", 128'(random_o), 128'(12)); tick();
        chk("w12_e", 128'(random_o), 128'(15)); tick();
        tick();
        chk("w12_f", 128'(random_o), 128'(13));
        cp0_wired_we = 1'b1;
        tick();
        cp0_wired_we = 1'b0;
        chk("wwe_reload", 128'(random_o), 128'(15));
        cp0_wired = 4'd0;

        // TLBWI, index 5
        xcfg = rnd86();
        issue(2'd2, 4'd5, xcfg);
        chk("wi_we1",  128'(tlb_we), 128'(1));
        chk("wi_idx",  128'(tlb_we_index), 128'(5));
        chk("wi_cfg",  128'(tlb_config), 128'(xcfg));
        chk("wi_rdy1", 128'(op_ready), 128'(0));
        tick();
        chk("wi_we2",  128'(tlb_we), 128'(0));
        tick();
        chk("wi_rv",   128'(res_valid), 128'(1));
        chk("wi_rt",   128'(res_type), 128'(2));
        chk("wi_rdy3", 128'(op_ready), 128'(0));
        tick();
        chk("wi_rdy4", 128'(op_ready), 128'(1));

        // TLBP hit, then miss
        tlb_p_res_i = 32'h0000_0007;
        issue(2'd0, 4'd0, rnd86());
        chk("p_p1", 128'(tlb_p), 128'(1));
        tick();
        chk("p_p2", 128'(tlb_p), 128'(0));
        tick();
        chk("p_hit", 128'(res_index), 128'(32'h7));
        tick();
        tlb_p_res_i = 32'h8000_0000;
        issue(2'd0, 4'd0, rnd86());
        repeat (2) tick();
        chk("p_miss", 128'(res_index), 128'(32'h8000_0000));
        tick();

        // TLBR, index 3
        pcfg = rnd86();
        tlb_read_config_i = pcfg;
        issue(2'd1, 4'd3, rnd86());
        chk("r_idx", 128'(tlb_read_index), 128'(3));
        chk("r_nostb", 128'({tlb_we, tlb_p}), 128'(0));
        repeat (2) tick();
        chk("r_cfg", 128'(res_config), 128'(pcfg));
        chk("r_type", 128'(res_type), 128'(1));
        tick();

        // TLBWR at Random=9, with a Wired write in the same cycle
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_rand == 4'd9) found = 1'b1; else tick();
        end
        chk("wr_found", 128'(found), 128'(1));
        op_valid = 1'b1; op_type = 2'd3; cp0_wired_we = 1'b1;
        tick();
        cp0_wired_we = 1'b0;
        chk("wr_idx", 128'(tlb_we_index), 128'(9));
        chk("wr_rand", 128'(random_o), 128'(15));
        // op_valid held high: the next strobe must come 4 cycles after this one
        op_type = 2'd2;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("b2b_we", 128'(tlb_we), 128'(k == 5));
        end
        op_valid = 1'b0;
        repeat (4) tick();

        // Reset during ISSUE. Also TLBP on the TLB-less instance.
        tlb_p_res_i = 32'h0000_0005;
        issue(2'd0, 4'd1, rnd86());
        chk("nt_rv", 128'(res_valid0), 128'(1));
        chk("nt_idx", 128'(res_index0), 128'(32'h8000_0000));
        chk("nt_p", 128'(tlb_p0), 128'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_stb", 128'({tlb_we, tlb_p}), 128'(0));
        chk("rs_rv", 128'(res_valid), 128'(0));
        chk("rs_rdy", 128'(op_ready), 128'(1));
        tick();
        chk("rs_rv2", 128'(res_valid), 128'(0));

        // Randomized traffic, checked every cycle against the model
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(199) == 0);
            op_valid     = $urandom_range(1);
            op_type      = 2'($urandom_range(3));
            cp0_index    = 4'($urandom_range(15));
            cp0_wired_we = ($urandom_range(15) == 0);
            if ($urandom_range(7) == 0) cp0_wired = 4'($urandom_range(15));
            cp0_tlb_config    = rnd86();
            tlb_p_res_i       = $urandom();
            tlb_read_config_i = rnd86();
            tick();
        end
        rst = 1'b0; op_valid = 1'b0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
